// File: rtl/datapath_pipe.sv
// datapath_pipe: two-stage execute datapath (E = operand latch + shift/ALU,
// R = registered result) with an embedded register file and NZCV status.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   instruction handshake from decode/controller
//   a_addr,b_addr,s_addr operand A, operand B and shift-amount registers
//   imm, sel_b_imm      immediate operand; selects imm for B (no shift)
//   sel_a_zero          force A to zero
//   sel_shift_reg       shift amount from s_addr register (else shift_imm)
//   shift_imm,shift_op  immediate shift amount; LSL/LSR/ASR/ROR
//   alu_op              ADD SUB AND ORR EOR MOV RSB PASSA
//   wr_en,wr_addr       write result back on retire
//   set_flags           update status on retire
//   ldr_en/addr/data    external (load) register write, every cycle asserted
//   out_valid/out_ready result handshake to memory/writeback
//   out_data,out_flags  registered result and its NZCV
//   status              architectural NZCV
module datapath_pipe #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16,
    parameter int FWD_EN = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [$clog2(NREG)-1:0]     a_addr,
    input  logic [$clog2(NREG)-1:0]     b_addr,
    input  logic [$clog2(NREG)-1:0]     s_addr,
    input  logic [DATA_W-1:0]           imm,
    input  logic                        sel_b_imm,
    input  logic                        sel_a_zero,
    input  logic                        sel_shift_reg,
    input  logic [$clog2(DATA_W)-1:0]   shift_imm,
    input  logic [1:0]                  shift_op,
    input  logic [2:0]                  alu_op,
    input  logic                        wr_en,
    input  logic [$clog2(NREG)-1:0]     wr_addr,
    input  logic                        set_flags,
    input  logic                        ldr_en,
    input  logic [$clog2(NREG)-1:0]     ldr_addr,
    input  logic [DATA_W-1:0]           ldr_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [3:0]                  out_flags,
    output logic [3:0]                  status
);
    localparam int AW  = $clog2(NREG);
    localparam int SW  = $clog2(DATA_W);
    localparam int MSB = DATA_W - 1;

    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_ORR = 3'd3,
                           OP_EOR = 3'd4, OP_MOV = 3'd5, OP_RSB = 3'd6, OP_PASSA = 3'd7;

    typedef struct packed {
        logic [DATA_W-1:0] a, b, s, imm;
        logic              sel_b_imm, sel_a_zero, sel_shift_reg;
        logic [SW-1:0]     shift_imm;
        logic [1:0]        shift_op;
        logic [2:0]        alu_op;
        logic              wr_en;
        logic [AW-1:0]     wr_addr;
        logic              set_flags;
    } e_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [3:0]        flags;
        logic              wr_en;
        logic [AW-1:0]     wr_addr;
        logic              set_flags;
    } r_t;

    logic [1:0]        vld_pipe;   // [0] = E stage valid, [1] = R stage valid
    e_t                e_q, e_d;
    r_t                r_q, r_d;
    logic [DATA_W-1:0] regs [NREG];

    logic              adv, retire;
    logic [DATA_W-1:0] alu_res;
    logic [3:0]        alu_flags;

    assign out_valid = vld_pipe[1];
    assign out_data  = r_q.data;
    assign out_flags = r_q.flags;
    assign adv       = !vld_pipe[1] || out_ready;
    assign in_ready  = adv;
    assign retire    = vld_pipe[1] && out_ready;

    // Operand fetch for A (0), B (1), S (2): youngest in-flight writer wins,
    // then the load port, then the register file.
    logic [2:0][AW-1:0]     src_addr;
    logic [2:0][DATA_W-1:0] src_val;
    assign src_addr = {s_addr, b_addr, a_addr};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            src_val[i] = regs[src_addr[i]];
            if (FWD_EN != 0) begin
                if (vld_pipe[0] && e_q.wr_en && e_q.wr_addr == src_addr[i])
                    src_val[i] = alu_res;
                else if (vld_pipe[1] && r_q.wr_en && r_q.wr_addr == src_addr[i])
                    src_val[i] = r_q.data;
                else if (ldr_en && ldr_addr == src_addr[i])
                    src_val[i] = ldr_data;
            end
        end
    end

    always_comb begin
        e_d               = '0;
        e_d.a             = src_val[0];
        e_d.b             = src_val[1];
        e_d.s             = src_val[2];
        e_d.imm           = imm;
        e_d.sel_b_imm     = sel_b_imm;
        e_d.sel_a_zero    = sel_a_zero;
        e_d.sel_shift_reg = sel_shift_reg;
        e_d.shift_imm     = shift_imm;
        e_d.shift_op      = shift_op;
        e_d.alu_op        = alu_op;
        e_d.wr_en         = wr_en;
        e_d.wr_addr       = wr_addr;
        e_d.set_flags     = set_flags;
    end

    // Barrel shifter on the latched B; ROR takes the low half of {b,b} >> n.
    logic [SW-1:0]       shamt;
    logic [2*DATA_W-1:0] rot;
    logic [DATA_W-1:0]   shifted, a_op, b_op;

    assign shamt = e_q.sel_shift_reg ? SW'(e_q.s) : e_q.shift_imm;
    assign rot   = {e_q.b, e_q.b} >> shamt;

    always_comb begin
        case (e_q.shift_op)
            2'd0:    shifted = e_q.b << shamt;
            2'd1:    shifted = e_q.b >> shamt;
            2'd2:    shifted = $signed(e_q.b) >>> shamt;
            default: shifted = rot[DATA_W-1:0];
        endcase
    end

    assign a_op = e_q.sel_a_zero ? '0 : e_q.a;
    assign b_op = e_q.sel_b_imm ? e_q.imm : shifted;

    // C/V for logic ops come from the newest flag-setting instruction, which
    // may still be waiting in R, so program order is preserved.
    logic cur_c, cur_v, c, v;
    logic [DATA_W:0] sum;
    assign cur_c = (vld_pipe[1] && r_q.set_flags) ? r_q.flags[1] : status[1];
    assign cur_v = (vld_pipe[1] && r_q.set_flags) ? r_q.flags[0] : status[0];

    always_comb begin
        sum     = '0;
        alu_res = '0;
        c       = cur_c;
        v       = cur_v;
        case (e_q.alu_op)
            OP_ADD: begin
                sum     = {1'b0, a_op} + {1'b0, b_op};
                alu_res = sum[DATA_W-1:0];
                c       = sum[DATA_W];
                v       = (a_op[MSB] == b_op[MSB]) && (alu_res[MSB] != a_op[MSB]);
            end
            OP_SUB: begin
                sum     = {1'b0, a_op} + {1'b0, ~b_op} + (DATA_W+1)'(1);
                alu_res = sum[DATA_W-1:0];
                c       = sum[DATA_W];
                v       = (a_op[MSB] != b_op[MSB]) && (alu_res[MSB] != a_op[MSB]);
            end
            OP_RSB: begin
                sum     = {1'b0, b_op} + {1'b0, ~a_op} + (DATA_W+1)'(1);
                alu_res = sum[DATA_W-1:0];
                c       = sum[DATA_W];
                v       = (a_op[MSB] != b_op[MSB]) && (alu_res[MSB] != b_op[MSB]);
            end
            OP_AND:   alu_res = a_op & b_op;
            OP_ORR:   alu_res = a_op | b_op;
            OP_EOR:   alu_res = a_op ^ b_op;
            OP_MOV:   alu_res = b_op;
            OP_PASSA: alu_res = a_op;
            default:  alu_res = '0;
        endcase
    end

    assign alu_flags = {alu_res[MSB], alu_res == '0, c, v};

    // Bubbles carry no write or flag intent into R.
    always_comb begin
        r_d           = '0;
        r_d.data      = alu_res;
        r_d.flags     = alu_flags;
        r_d.wr_en     = vld_pipe[0] && e_q.wr_en;
        r_d.wr_addr   = e_q.wr_addr;
        r_d.set_flags = vld_pipe[0] && e_q.set_flags;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            e_q      <= '0;
            r_q      <= '0;
            status   <= '0;
        end else begin
            if (adv) begin
                vld_pipe <= {vld_pipe[0], in_valid};
                e_q      <= e_d;
                r_q      <= r_d;
            end
            if (retire && r_q.set_flags)
                status <= r_q.flags;
        end
    end

    // Retire beats a same-cycle load to the same register.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst)
                regs[i] <= '0;
            else if (retire && r_q.wr_en && r_q.wr_addr == AW'(i))
                regs[i] <= r_q.data;
            else if (ldr_en && ldr_addr == AW'(i))
                regs[i] <= ldr_data;
        end
    end
endmodule

// File: tb/tb_datapath_pipe.sv
// Self-checking bench for datapath_pipe: directed scenarios plus randomized
// traffic, checked against an in-order architectural model of the ISA.
module tb_datapath_pipe;
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [3:0]  a_addr = '0, b_addr = '0, s_addr = '0, wr_addr = '0, ldr_addr = '0;
    logic [31:0] imm = '0, ldr_data = '0;
    logic        sel_b_imm = 1'b0, sel_a_zero = 1'b0, sel_shift_reg = 1'b0;
    logic [4:0]  shift_imm = '0;
    logic [1:0]  shift_op = '0;
    logic [2:0]  alu_op = '0;
    logic        wr_en = 1'b0, set_flags = 1'b0, ldr_en = 1'b0;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_flags, status;

    datapath_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_addr(a_addr), .b_addr(b_addr), .s_addr(s_addr), .imm(imm),
        .sel_b_imm(sel_b_imm), .sel_a_zero(sel_a_zero), .sel_shift_reg(sel_shift_reg),
        .shift_imm(shift_imm), .shift_op(shift_op), .alu_op(alu_op),
        .wr_en(wr_en), .wr_addr(wr_addr), .set_flags(set_flags),
        .ldr_en(ldr_en), .ldr_addr(ldr_addr), .ldr_data(ldr_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_flags(out_flags), .status(status)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Architectural model: registers and flags updated in program order at
    // issue; each accepted instruction queues its expected result.
    typedef struct {
        logic [31:0] data;
        logic [3:0]  flags;
        logic        wr_en;
        logic [3:0]  wr_addr;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_reg [16];
    logic [3:0]  m_status = '0;
    logic [31:0] last_data = '0, hold_data = '0;
    logic [3:0]  last_flags = '0, prev_flags = '0, hold_flags = '0;
    logic        hold = 1'b0;

    function automatic logic [31:0] shf(input logic [31:0] x, input logic [1:0] op, input int n);
        case (op)
            2'd0:    return x << n;
            2'd1:    return x >> n;
            2'd2:    return $signed(x) >>> n;
            default: return (n == 0) ? x : ((x >> n) | (x << (32 - n)));
        endcase
    endfunction

    function automatic logic ovf(input longint x);
        return (x > 64'sd2147483647) || (x < -64'sd2147483648);
    endfunction

    task automatic model_exec();
        logic [31:0] a, b, r;
        logic        c, v;
        longint      sa, sb;
        exp_t        e;
        a  = sel_a_zero ? 32'd0 : m_reg[a_addr];
        b  = sel_b_imm ? imm
                       : shf(m_reg[b_addr], shift_op, sel_shift_reg ? int'(m_reg[s_addr] % 32) : int'(shift_imm));
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c  = m_status[1];
        v  = m_status[0];
        case (alu_op)
            3'd0: begin r = a + b; c = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF; v = ovf(sa + sb); end
            3'd1: begin r = a - b; c = (a >= b); v = ovf(sa - sb); end
            3'd6: begin r = b - a; c = (b >= a); v = ovf(sb - sa); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = b;
            default: r = a;
        endcase
        e.data    = r;
        e.flags   = {r[31], r == 32'd0, c, v};
        e.wr_en   = wr_en;
        e.wr_addr = wr_addr;
        if (set_flags) m_status = e.flags;
        if (wr_en) m_reg[wr_addr] = r;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            for (int i = 0; i < 16; i++) m_reg[i] = '0;
            m_status = '0;
            hold = 1'b0;
        end else begin
            logic sup;
            if (hold) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, hold_data);
                chk("stall_flags", out_flags, hold_flags);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("spurious_out", out_valid, 0);
                else begin
                    chk("out_data", out_data, q[0].data);
                    chk("out_flags", out_flags, q[0].flags);
                end
            end
            // A load is overwritten by any in-flight writer of the same register.
            if (ldr_en) begin
                sup = 1'b0;
                foreach (q[i]) if (q[i].wr_en && q[i].wr_addr == ldr_addr) sup = 1'b1;
                if (!sup) m_reg[ldr_addr] = ldr_data;
            end
            if (out_valid && out_ready && q.size() != 0) begin
                prev_flags = last_flags;
                last_data  = out_data;
                last_flags = out_flags;
                void'(q.pop_front());
            end
            if (in_valid && in_ready) model_exec();
            hold       = out_valid && !out_ready;
            hold_data  = out_data;
            hold_flags = out_flags;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] s, input logic we, input logic [3:0] wa,
                         input logic sf, input logic bimm, input logic [31:0] im,
                         input logic azero, input logic sreg, input logic [4:0] shi,
                         input logic [1:0] sop);
        int n;
        alu_op = op; a_addr = a; b_addr = b; s_addr = s; wr_en = we; wr_addr = wa;
        set_flags = sf; sel_b_imm = bimm; imm = im; sel_a_zero = azero;
        sel_shift_reg = sreg; shift_imm = shi; shift_op = sop; in_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!in_ready && n < 50);
        if (!in_ready) chk("issue_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic ldr(input logic [3:0] a, input logic [31:0] d);
        ldr_en = 1'b1; ldr_addr = a; ldr_data = d;
        @(posedge clk); #1;
        ldr_en = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1; in_valid = 1'b0; ldr_en = 1'b0;
        while ((q.size() != 0 || out_valid) && n < 40) begin @(posedge clk); #1; n++; end
        chk("drain", out_valid, 0);
    endtask

    task automatic rd(input logic [3:0] r);
        issue(3'd7, r, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 2'd0);
        drain();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_flags", out_flags, 0);
        chk("rst_status", status, 0);
        rst = 1'b0;

        // Basic ADD and its latency.
        ldr(4'd1, 32'd5);
        ldr(4'd2, 32'd3);
        issue(3'd0, 4'd1, 4'd2, 4'd0, 1'b1, 4'd3, 1'b0, 1'b0, 0, 1'b0, 1'b0, 5'd0, 2'd0);
        @(negedge clk); chk("lat_e", out_valid, 0);
        @(negedge clk); chk("lat_r", out_valid, 1);
        @(posedge clk); #1;
        drain();
        chk("add_res", last_data, 32'd8);
        chk("add_status", status, 4'b0000);
        rd(4'd3);
        chk("r3", last_data, 32'd8);

        // Back-to-back dependency through E-stage forwarding.
        issue(3'd0, 4'd1, 4'd2, 4'd0, 1'b1, 4'd4, 1'b0, 1'b0, 0, 1'b0, 1'b0, 5'd0, 2'd0);
        issue(3'd1, 4'd4, 4'd1, 4'd0, 1'b1, 4'd5, 1'b1, 1'b0, 0, 1'b0, 1'b0, 5'd0, 2'd0);
        drain();
        chk("sub_res", last_data, 32'd3);
        chk("sub_status", status, 4'b0010);

        // Shifter.
        ldr(4'd7, 32'h8000_0000);
        ldr(4'd9, 32'd4);
        ldr(4'd10, 32'h0000_000F);
        issue(3'd5, 4'd0, 4'd7, 4'd9, 1'b0, 4'd0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 5'd0, 2'd2);
        drain(); chk("asr_reg", last_data, 32'hF800_0000);
        issue(3'd5, 4'd0, 4'd10, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 5'd4, 2'd3);
        drain(); chk("ror_imm", last_data, 32'hF000_0000);
        issue(3'd5, 4'd0, 4'd7, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 5'd0, 2'd1);
        drain(); chk("lsr_zero", last_data, 32'h8000_0000);

        // Backpressure with two in flight, second depends on first.
        out_ready = 1'b0;
        issue(3'd0, 4'd1, 4'd2, 4'd0, 1'b1, 4'd11, 1'b0, 1'b0, 0, 1'b0, 1'b0, 5'd0, 2'd0);
        issue(3'd0, 4'd11, 4'd1, 4'd0, 1'b1, 4'd12, 1'b0, 1'b0, 0, 1'b0, 1'b0, 5'd0, 2'd0);
        repeat (3) begin
            @(negedge clk); chk("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        drain();
        chk("bp_last", last_data, 32'd13);
        rd(4'd12);
        chk("r12", last_data, 32'd13);

        // Signed overflow, then a logic op that keeps C and V.
        ldr(4'd13, 32'h7FFF_FFFF);
        ldr(4'd14, 32'd1);
        issue(3'd0, 4'd13, 4'd14, 4'd0, 1'b1, 4'd15, 1'b1, 1'b0, 0, 1'b0, 1'b0, 5'd0, 2'd0);
        issue(3'd2, 4'd13, 4'd14, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 5'd0, 2'd0);
        drain();
        chk("ovf_flags", prev_flags, 4'b1001);
        chk("and_flags", last_flags, 4'b0001);
        chk("and_status", status, 4'b0001);
        rd(4'd15);
        chk("r15", last_data, 32'h8000_0000);

        // Retire and load to the same register in the same cycle.
        out_ready = 1'b0;
        issue(3'd0, 4'd1, 4'd2, 4'd0, 1'b1, 4'd6, 1'b0, 1'b0, 0, 1'b0, 1'b0, 5'd0, 2'd0);
        @(posedge clk); #1;
        chk("col_valid", out_valid, 1);
        ldr_en = 1'b1; ldr_addr = 4'd6; ldr_data = 32'hDEAD_BEEF; out_ready = 1'b1;
        @(posedge clk); #1;
        ldr_en = 1'b0;
        drain();
        rd(4'd6);
        chk("collide_r6", last_data, 32'd8);

        // Reset with two instructions in flight.
        out_ready = 1'b0;
        issue(3'd0, 4'd1, 4'd2, 4'd0, 1'b1, 4'd3, 1'b1, 1'b0, 0, 1'b0, 1'b0, 5'd0, 2'd0);
        issue(3'd1, 4'd2, 4'd1, 4'd0, 1'b1, 4'd4, 1'b1, 1'b0, 0, 1'b0, 1'b0, 5'd0, 2'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_status", status, 0);
        @(posedge clk); #1;
        rd(4'd1);
        chk("rst_r1", last_data, 0);

        // Randomized traffic with backpressure, loads and bubbles.
        for (int k = 0; k < 800; k++) begin
            out_ready     = ($urandom_range(0, 3) != 0);
            ldr_en        = ($urandom_range(0, 3) == 0);
            ldr_addr      = 4'($urandom);
            ldr_data      = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
            in_valid      = ($urandom_range(0, 3) != 0);
            a_addr        = 4'($urandom);
            b_addr        = 4'($urandom);
            s_addr        = 4'($urandom);
            wr_addr       = 4'($urandom);
            imm           = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
            sel_b_imm     = 1'($urandom);
            sel_a_zero    = ($urandom_range(0, 7) == 0);
            sel_shift_reg = 1'($urandom);
            shift_imm     = 5'($urandom);
            shift_op      = 2'($urandom);
            alu_op        = 3'($urandom);
            wr_en         = ($urandom_range(0, 3) != 0);
            set_flags     = 1'($urandom);
            @(posedge clk); #1;
        end
        drain();
        chk("end_status", status, m_status);
        for (int r = 0; r < 16; r++) rd(4'(r));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
